ascii_int_parser: RTL and testbench

ASCII_INT_PARSER -- requirements
Module: ascii_int_parser

---
 rtl/aoc_pkg.sv | 17 +
 rtl/ascii_classify.sv | 22 ++
 rtl/ascii_int_parser.sv | 157 +++++++++++++++
 tb/tb_ascii_int_parser.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aoc_pkg.sv
// Shared ASCII constants and parser state type for the puzzle-input parsing blocks.
package aoc_pkg;

  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam logic [7:0] ASCII_NINE    = 8'h39;
  localparam logic [7:0] ASCII_NEWLINE = 8'h0A;
  localparam logic [7:0] ASCII_CR      = 8'h0D;
  localparam logic [7:0] ASCII_MINUS   = 8'h2D;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GAP,
    ST_NUM,
    ST_DONE
  } parser_state_t;

endpackage

// File: rtl/ascii_classify.sv
// Combinational character-class decoder for the integer parser.
module ascii_classify
  import aoc_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic       is_digit,
  output logic [3:0] digit,
  output logic       is_newline,
  output logic       is_cr,
  output logic       is_minus
);

  // The low nibble of '0'..'9' is the digit value itself; it is only meaningful when is_digit is set.
  always_comb begin
    is_digit   = (in_byte >= ASCII_ZERO) && (in_byte <= ASCII_NINE);
    digit      = in_byte[3:0];
    is_newline = (in_byte == ASCII_NEWLINE);
    is_cr      = (in_byte == ASCII_CR);
    is_minus   = (in_byte == ASCII_MINUS);
  end

endmodule

// File: rtl/ascii_int_parser.sv
// Streams ASCII bytes into decimal integer tokens with line and file boundary flags.
// Define PARSER_SIGNED_EN to accept a leading '-' and emit two's-complement negatives.
module ascii_int_parser
  import aoc_pkg::*;
#(
  parameter int BIT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [7:0]           in_byte,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [BIT_WIDTH-1:0] out_data,
  output logic                 out_eol,
  output logic                 out_blank,
  output logic                 out_last,
  input  logic                 out_full,
  output logic                 err_overflow,
  output logic [31:0]          token_count
);

  localparam int WIDE = BIT_WIDTH + 4;

  parser_state_t        state, state_next;
  logic [BIT_WIDTH-1:0] acc, acc_next, acc_base, emit_value;
  logic [WIDE-1:0]      acc_wide;
  logic                 is_digit, is_newline, is_cr, is_minus;
  logic [3:0]           digit;
  logic                 byte_fire, tok_fire, active;
  logic                 emit, emit_eol, emit_blank, emit_last, ovf_hit;

  ascii_classify u_classify (
    .in_byte    (in_byte),
    .is_digit   (is_digit),
    .digit      (digit),
    .is_newline (is_newline),
    .is_cr      (is_cr),
    .is_minus   (is_minus)
  );

  // DONE swallows everything, so it never needs to wait for the token slot.
  assign in_ready  = (state == ST_DONE) || !out_valid || !out_full;
  assign byte_fire = in_valid && in_ready;
  assign tok_fire  = out_valid && !out_full;
  assign active    = byte_fire && (state != ST_DONE) && (in_last || !is_cr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      acc   <= '0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
    end
  end

  always_comb begin
    state_next = state;
    if (active) begin
      if (in_last)
        state_next = ST_DONE;
      else if (is_digit)
        state_next = ST_NUM;
      else if (is_newline)
        state_next = ST_IDLE;
      else if (state == ST_NUM)
        state_next = ST_GAP;
    end
  end

  // The widened product can never wrap, so any bit above BIT_WIDTH is a genuine overflow.
  always_comb begin
    acc_base   = (state == ST_NUM) ? acc : '0;
    acc_wide   = {4'd0, acc_base} * WIDE'(10) + WIDE'(digit);
    acc_next   = acc;
    ovf_hit    = 1'b0;
    emit       = 1'b0;
    emit_eol   = 1'b0;
    emit_blank = 1'b0;
    emit_last  = 1'b0;
    if (active) begin
      if (is_digit) begin
        acc_next = acc_wide[BIT_WIDTH-1:0];
        ovf_hit  = |acc_wide[WIDE-1:BIT_WIDTH];
      end
      if (in_last) begin
        emit       = 1'b1;
        emit_eol   = 1'b1;
        emit_last  = 1'b1;
        emit_blank = !is_digit && (state != ST_NUM);
      end else if (is_newline) begin
        emit       = (state != ST_GAP);
        emit_eol   = 1'b1;
        emit_blank = (state == ST_IDLE);
      end else if (!is_digit && (state == ST_NUM)) begin
        emit = 1'b1;
      end
    end
  end

`ifdef PARSER_SIGNED_EN
  logic neg, neg_next;

  // A sign only survives until the next non-digit; a digit carries it into the number.
  always_comb begin
    neg_next = neg;
    if (active) begin
      if (is_minus && (state != ST_NUM) && !in_last)
        neg_next = 1'b1;
      else if (!is_digit)
        neg_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      neg <= 1'b0;
    else
      neg <= neg_next;
  end

  assign emit_value = neg ? -acc_next : acc_next;
`else
  logic unused_minus;
  assign unused_minus = is_minus;
  assign emit_value   = acc_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_eol      <= 1'b0;
      out_blank    <= 1'b0;
      out_last     <= 1'b0;
      err_overflow <= 1'b0;
      token_count  <= '0;
    end else begin
      if (emit) begin
        out_valid <= 1'b1;
        out_data  <= emit_blank ? '0 : emit_value;
        out_eol   <= emit_eol;
        out_blank <= emit_blank;
        out_last  <= emit_last;
      end else if (tok_fire) begin
        out_valid <= 1'b0;
      end
      if (ovf_hit)
        err_overflow <= 1'b1;
      if (tok_fire)
        token_count <= token_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_ascii_int_parser.sv
// Self-checking bench for ascii_int_parser: a 32-bit and an 8-bit instance against a string-level model.
module tb_ascii_int_parser;

  typedef struct packed {
    logic [31:0] data;
    logic        eol;
    logic        blank;
    logic        last;
  } tok_t;

`ifdef PARSER_SIGNED_EN
  localparam bit SIGNED_MODE = 1'b1;
`else
  localparam bit SIGNED_MODE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       drv_valid = 1'b0;
  logic [7:0] drv_byte = 8'h00;
  logic       drv_last = 1'b0;
  logic       out_full = 1'b0;
  bit         cur_sel = 1'b0;

  logic        in_valid0, in_ready0, out_valid0, out_eol0, out_blank0, out_last0, err0;
  logic [31:0] out_data0, count0;
  logic        in_valid1, in_ready1, out_valid1, out_eol1, out_blank1, out_last1, err1;
  logic [7:0]  out_data1;
  logic [31:0] count1;

  int vectors = 0;
  int miscompares = 0;
  bit saw_stall = 1'b0;

  tok_t exp0[$], exp1[$], got0[$], got1[$];
  bit          m_num[2], m_line[2], m_neg[2], m_done[2], m_ovf[2];
  longint unsigned m_val[2];
  int          m_width[2] = '{32, 8};

  always #5 clk = ~clk;

  assign in_valid0 = drv_valid && !cur_sel;
  assign in_valid1 = drv_valid && cur_sel;

  ascii_int_parser #(.BIT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_byte(drv_byte), .in_last(drv_last),
    .in_ready(in_ready0), .out_valid(out_valid0), .out_data(out_data0), .out_eol(out_eol0),
    .out_blank(out_blank0), .out_last(out_last0), .out_full(out_full),
    .err_overflow(err0), .token_count(count0)
  );

  ascii_int_parser #(.BIT_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_byte(drv_byte), .in_last(drv_last),
    .in_ready(in_ready1), .out_valid(out_valid1), .out_data(out_data1), .out_eol(out_eol1),
    .out_blank(out_blank1), .out_last(out_last1), .out_full(out_full),
    .err_overflow(err1), .token_count(count1)
  );

  function automatic tok_t mk(input logic [31:0] d, input logic e, input logic b, input logic l);
    return {d, e, b, l};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic pushExp(input int sel, input tok_t t);
    if (sel == 0) exp0.push_back(t);
    else exp1.push_back(t);
  endtask

  function automatic logic [31:0] modelValue(input int sel);
    longint unsigned lim = 64'd1 << m_width[sel];
    if (m_neg[sel] && m_val[sel] != 0) return 32'(lim - m_val[sel]);
    return 32'(m_val[sel]);
  endfunction

  task automatic modelReset();
    for (int s = 0; s < 2; s++) begin
      m_num[s] = 0; m_line[s] = 0; m_neg[s] = 0; m_done[s] = 0; m_ovf[s] = 0; m_val[s] = 0;
    end
    exp0.delete(); exp1.delete(); got0.delete(); got1.delete();
  endtask

  // Text-level reading of the token rules, applied once per accepted byte.
  task automatic modelByte(input int sel, input logic [7:0] b, input logic last);
    longint unsigned lim = 64'd1 << m_width[sel];
    bit isd = (b >= 8'h30) && (b <= 8'h39);
    if (m_done[sel]) return;
    if (b == 8'h0D && !last) return;
    if (isd) begin
      if (!m_num[sel]) m_val[sel] = 0;
      m_val[sel] = m_val[sel] * 10 + (longint'(b) - 48);
      if (m_val[sel] >= lim) begin
        m_ovf[sel] = 1;
        m_val[sel] = m_val[sel] % lim;
      end
      m_num[sel] = 1;
    end
    if (last) begin
      pushExp(sel, m_num[sel] ? mk(modelValue(sel), 1, 0, 1) : mk(0, 1, 1, 1));
      m_done[sel] = 1;
      return;
    end
    if (isd) return;
    if (b == 8'h0A) begin
      if (m_num[sel]) pushExp(sel, mk(modelValue(sel), 1, 0, 0));
      else if (!m_line[sel]) pushExp(sel, mk(0, 1, 1, 0));
      m_num[sel] = 0; m_line[sel] = 0; m_neg[sel] = 0;
    end else if (m_num[sel]) begin
      pushExp(sel, mk(modelValue(sel), 0, 0, 0));
      m_num[sel] = 0; m_line[sel] = 1; m_neg[sel] = 0;
    end else begin
      m_neg[sel] = SIGNED_MODE && (b == 8'h2D);
    end
  endtask

  logic [1:0]  ov, rdy;
  tok_t        cur[2], prev_tok[2];
  bit   [1:0]  prev_blk;

  assign ov     = {out_valid1, out_valid0};
  assign rdy    = {in_ready1, in_ready0};
  assign cur[0] = {out_data0, out_eol0, out_blank0, out_last0};
  assign cur[1] = {24'd0, out_data1, out_eol1, out_blank1, out_last1};

  // Per-cycle compare: ready rule, hold-while-blocked, and every accepted token against the model.
  always @(negedge clk) begin
    if (rst) begin
      prev_blk = 2'b00;
    end else begin
      for (int s = 0; s < 2; s++) begin
        tok_t e;
        bit   none;
        checkOutput(s == 0 ? "in_ready32" : "in_ready8", rdy[s], m_done[s] || !ov[s] || !out_full);
        if (prev_blk[s]) begin
          checkOutput("hold_valid", ov[s], 1);
          checkOutput("hold_token", cur[s], prev_tok[s]);
        end
        if (ov[s] && !out_full) begin
          none = (s == 0) ? (exp0.size() == 0) : (exp1.size() == 0);
          if (none) begin
            checkOutput("unexpected_token", cur[s], 0);
          end else begin
            e = (s == 0) ? exp0.pop_front() : exp1.pop_front();
            checkOutput(s == 0 ? "token32" : "token8", cur[s], e);
          end
          if (s == 0) got0.push_back(cur[s]);
          else got1.push_back(cur[s]);
        end
        prev_blk[s] = ov[s] && out_full;
        prev_tok[s] = cur[s];
      end
    end
  end

  task automatic doReset();
    rst = 1; drv_valid = 0; drv_last = 0;
    repeat (2) @(posedge clk);
    #1;
    modelReset();
    rst = 0;
    @(negedge clk);
    checkOutput("rst_in_ready", {in_ready1, in_ready0}, 2'b11);
    checkOutput("rst_out_valid", {out_valid1, out_valid0}, 0);
    checkOutput("rst_flags", {out_eol0, out_blank0, out_last0, out_eol1, out_blank1, out_last1}, 0);
    checkOutput("rst_out_data", {out_data1, out_data0}, 0);
    checkOutput("rst_err", {err1, err0}, 0);
    checkOutput("rst_token_count", {count1, count0}, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b, input logic last);
    bit got = 0;
    drv_byte = b; drv_last = last; drv_valid = 1;
    for (int t = 0; t < 100 && !got; t++) begin
      @(negedge clk);
      got = cur_sel ? in_ready1 : in_ready0;
      if (!got) saw_stall = 1;
      @(posedge clk);
      #1;
    end
    drv_valid = 0; drv_last = 0;
    checkOutput("byte_accepted", got, 1);
    if (got) modelByte(cur_sel, b, last);
  endtask

  task automatic applyStimulus(input string s, input bit last_on_final);
    for (int i = 0; i < s.len(); i++)
      sendByte(s[i], last_on_final && (i == s.len() - 1));
  endtask

  task automatic waitDrain(input int sel);
    for (int t = 0; t < 60; t++) begin
      if ((sel == 0 ? exp0.size() : exp1.size()) == 0 && !out_full) break;
      @(posedge clk);
      #1;
    end
    repeat (2) @(posedge clk);
    #1;
    checkOutput("drain_pending", sel == 0 ? exp0.size() : exp1.size(), 0);
    checkOutput("err_overflow", sel == 0 ? err0 : err1, m_ovf[sel]);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cur_sel = 0;
    doReset();

    applyStimulus("12 345\n", 0);
    waitDrain(0);
    checkOutput("t1_ntok", got0.size(), 2);
    checkOutput("t1_tok0", got0[0], mk(12, 0, 0, 0));
    checkOutput("t1_tok1", got0[1], mk(345, 1, 0, 0));
    checkOutput("t1_count", count0, 2);

    doReset();
    applyStimulus("7\n\n8", 1);
    applyStimulus("9\n", 0);
    waitDrain(0);
    checkOutput("t2_ntok", got0.size(), 3);
    checkOutput("t2_tok0", got0[0], mk(7, 1, 0, 0));
    checkOutput("t2_tok1", got0[1], mk(0, 1, 1, 0));
    checkOutput("t2_tok2", got0[2], mk(8, 1, 0, 1));
    checkOutput("t2_count", count0, 3);

    doReset();
    saw_stall = 0;
    fork
      begin
        out_full = 1;
        repeat (5) @(posedge clk);
        #1;
        out_full = 0;
      end
    join_none
    applyStimulus("1,2,3\n", 0);
    waitDrain(0);
    checkOutput("t3_stalled", saw_stall, 1);
    checkOutput("t3_ntok", got0.size(), 3);
    checkOutput("t3_tok0", got0[0], mk(1, 0, 0, 0));
    checkOutput("t3_tok2", got0[2], mk(3, 1, 0, 0));
    checkOutput("t3_count", count0, 3);

    doReset();
    applyStimulus("98", 0);
    doReset();
    applyStimulus("4\n", 0);
    waitDrain(0);
    checkOutput("t4_ntok", got0.size(), 1);
    checkOutput("t4_tok0", got0[0], mk(4, 1, 0, 0));
    checkOutput("t4_count", count0, 1);

    out_full = 1;
    applyStimulus("6,", 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("t5_pending", out_valid0, 1);
    doReset();
    out_full = 0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t5_discarded", got0.size(), 0);

    doReset();
    applyStimulus("-5 - 3\n", 0);
    waitDrain(0);
    checkOutput("t6_ntok", got0.size(), 2);
`ifdef PARSER_SIGNED_EN
    checkOutput("t6_tok0", got0[0], mk(32'hFFFF_FFFB, 0, 0, 0));
`else
    checkOutput("t6_tok0", got0[0], mk(5, 0, 0, 0));
`endif
    checkOutput("t6_tok1", got0[1], mk(3, 1, 0, 0));

    doReset();
    applyStimulus("4\r2\r\n8 \n\n", 0);
    waitDrain(0);
    checkOutput("t7_ntok", got0.size(), 3);
    checkOutput("t7_tok0", got0[0], mk(42, 1, 0, 0));
    checkOutput("t7_tok1", got0[1], mk(8, 0, 0, 0));
    checkOutput("t7_tok2", got0[2], mk(0, 1, 1, 0));

    doReset();
    applyStimulus("4294967295 ", 0);
    waitDrain(0);
    checkOutput("t8_max_noerr", err0, 0);
    applyStimulus("4294967296\n", 0);
    waitDrain(0);
    checkOutput("t8_tok0", got0[0], mk(32'hFFFF_FFFF, 0, 0, 0));
    checkOutput("t8_tok1", got0[1], mk(0, 1, 0, 0));
    checkOutput("t8_err", err0, 1);

    cur_sel = 1;
    doReset();
    applyStimulus("300\n", 0);
    waitDrain(1);
    checkOutput("t9_tok0", got1[0], mk(44, 1, 0, 0));
    checkOutput("t9_err", err1, 1);
    applyStimulus("5\n", 0);
    waitDrain(1);
    checkOutput("t9_tok1", got1[1], mk(5, 1, 0, 0));
    checkOutput("t9_err_sticky", err1, 1);
    checkOutput("t9_count", count1, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
